// File: rtl/audio_dac_tx.sv
// SPI frame transmitter for a DAC121S101 (PmodDA2): one 16-bit frame per sample tick,
// fed from a one-entry holding register with a valid/ready handshake.
module audio_dac_tx #(
  parameter int         CLK_DIV    = 4,
  parameter int         SAMPLE_DIV = 5000,
  parameter logic [1:0] PD_MODE    = 2'b00
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        sync_n,
  output logic        sclk,
  output logic        sdata,
  output logic        busy,
  output logic        underrun,
  output logic [1:0]  state_dbg
);

  // Handshake: a sample moves into the holding register when sample_valid && sample_ready
  // are both high at a rising CLK edge. sample_ready is registered and never depends on
  // sample_valid in the same cycle; once asserted, the producer keeps sample_in stable
  // until the transfer happens.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(2 * CLK_DIV - 1);

  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [11:0]   hold;
  logic          hold_full;
  logic          hold_full_nxt;
  logic [11:0]   last_sample;
  logic [DW-1:0] div_cnt;
  logic [4:0]    half_cnt;
  logic [15:0]   shreg;
  logic [15:0]   frame_word;
  logic          accept;
  logic          take;

  assign state_dbg  = state;
  assign tick       = (tick_cnt == TICK_LAST);
  assign accept     = sample_valid & sample_ready;
  assign take       = tick & (state == IDLE) & hold_full;
  assign frame_word = {2'b00, PD_MODE, (hold_full ? hold : last_sample)};

  always_comb begin
    hold_full_nxt = hold_full;
    if (accept)    hold_full_nxt = 1'b1;
    else if (take) hold_full_nxt = 1'b0;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A sample accepted in the tick cycle waits for the next frame; there is no bypass.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      hold         <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b1;
    end else begin
      hold_full    <= hold_full_nxt;
      sample_ready <= ~hold_full_nxt;
      if (accept) hold <= sample_in;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sync_n      <= 1'b1;
      sclk        <= 1'b1;
      sdata       <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
      last_sample <= '0;
      div_cnt     <= '0;
      half_cnt    <= '0;
      shreg       <= '0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= SHIFT;
            sync_n   <= 1'b0;
            sclk     <= 1'b1;
            busy     <= 1'b1;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= frame_word;
            sdata    <= frame_word[15];
            if (hold_full) last_sample <= hold;
            else           underrun    <= 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 1'b1;
            sclk     <= ~sclk;
            if (half_cnt == 5'd31) begin
              state  <= GAP;
              sclk   <= 1'b1;
              sync_n <= 1'b1;
              sdata  <= 1'b0;
            end else if (half_cnt[0]) begin
              // Odd count means this toggle is a rising edge: present the next bit.
              shreg <= {shreg[14:0], 1'b0};
              sdata <= shreg[14];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: reset state, frame content/timing, underrun,
// back-pressure, mid-frame reset abort and a PD_MODE=2'b11 instance.
module tb_audio_dac_tx;

  logic        clk;
  logic        rst1_n, rst2_n;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        sel;

  logic ready1, sync1, sclk1, sdata1, busy1, und1;
  logic ready2, sync2, sclk2, sdata2, busy2, und2;
  logic [1:0] st1, st2;

  logic mon_ready, mon_sync, mon_sclk, mon_sdata, mon_busy, mon_und;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] cap;
  int fall_cnt = 0;
  int tog_cnt = 0;
  int und_cnt = 0;

  audio_dac_tx #(.CLK_DIV(2), .SAMPLE_DIV(100), .PD_MODE(2'b00)) dut (
    .CLK(clk), .reset_n(rst1_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(ready1), .sync_n(sync1), .sclk(sclk1), .sdata(sdata1),
    .busy(busy1), .underrun(und1), .state_dbg(st1)
  );

  audio_dac_tx #(.CLK_DIV(2), .SAMPLE_DIV(100), .PD_MODE(2'b11)) dut_pd (
    .CLK(clk), .reset_n(rst2_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(ready2), .sync_n(sync2), .sclk(sclk2), .sdata(sdata2),
    .busy(busy2), .underrun(und2), .state_dbg(st2)
  );

  assign mon_ready = sel ? ready2 : ready1;
  assign mon_sync  = sel ? sync2  : sync1;
  assign mon_sclk  = sel ? sclk2  : sclk1;
  assign mon_sdata = sel ? sdata2 : sdata1;
  assign mon_busy  = sel ? busy2  : busy1;
  assign mon_und   = sel ? und2   : und1;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DAC-side model: capture on falling sclk while the frame is open
  always @(negedge mon_sclk) begin
    if (mon_sync === 1'b0) begin
      cap = {cap[14:0], mon_sdata};
      fall_cnt++;
    end
  end

  always @(mon_sclk) tog_cnt++;

  always @(negedge clk) if (mon_und === 1'b1) und_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic push(input logic [11:0] s, output int waited);
    waited = 0;
    @(negedge clk);
    sample_in    = s;
    sample_valid = 1'b1;
    while (!mon_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", {31'd0, mon_ready}, 32'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_frame(output logic [15:0] word, output int falls, output int low,
                            output int lat, output int gap);
    lat = 0;
    while (mon_sync && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("frame_start", {31'd0, mon_sync}, 32'd0);
    fall_cnt = 0;
    cap = '0;
    low = 0;
    while (!mon_sync && low < 400) begin
      low++;
      @(negedge clk);
    end
    gap = 0;
    while (mon_busy && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    word  = cap;
    falls = fall_cnt;
  endtask

  logic [15:0] w;
  int falls, low, lat, gap, waited, n;
  logic acc_busy;

  initial begin
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    sel = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;

    // 1: reset state
    @(negedge clk);
    tog_cnt = 0;
    repeat (4) @(negedge clk);
    check("rst_sync_n", {31'd0, sync1}, 32'd1);
    check("rst_sclk", {31'd0, sclk1}, 32'd1);
    check("rst_sdata", {31'd0, sdata1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_underrun", {31'd0, und1}, 32'd0);
    check("rst_ready", {31'd0, ready1}, 32'd1);
    check("rst_no_toggle", tog_cnt, 0);
    rst1_n = 1'b1;
    und_cnt = 0;

    // 2: first sample
    push(12'hA5C, waited);
    @(negedge clk);
    check("ready_low_when_full", {31'd0, ready1}, 32'd0);
    wait_frame(w, falls, low, lat, gap);
    check("f1_word", w, 16'h0A5C);
    check("f1_falls", falls, 16);
    check("f1_sync_low", low, 64);
    check("f1_gap", gap, 4);
    check("f1_ready_again", {31'd0, ready1}, 32'd1);
    check("f1_no_underrun", und_cnt, 0);

    // 3: underrun repeats the last sample
    und_cnt = 0;
    wait_frame(w, falls, low, lat, gap);
    check("f2_word", w, 16'h0A5C);
    check("f2_underrun", und_cnt, 1);
    check("f2_tick_period", lat + 64 + 4, 100);

    // 4: back-pressure
    und_cnt = 0;
    push(12'h123, waited);
    fork
      begin
        push(12'h456, waited);
        acc_busy = busy1;
      end
      wait_frame(w, falls, low, lat, gap);
    join
    check("f3_word", w, 16'h0123);
    check("stall_until_tick", {31'd0, acc_busy}, 32'd1);
    check("stall_waited", {31'd0, (waited > 20)}, 32'd1);
    wait_frame(w, falls, low, lat, gap);
    check("f4_word", w, 16'h0456);
    check("f34_no_underrun", und_cnt, 0);

    // 5: reset mid-frame
    push(12'h3C3, waited);
    n = 0;
    while (sync1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    fall_cnt = 0;
    n = 0;
    while (fall_cnt < 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_falls_seen", fall_cnt, 5);
    rst1_n = 1'b0;
    #1;
    check("abort_sync_n", {31'd0, sync1}, 32'd1);
    check("abort_sclk", {31'd0, sclk1}, 32'd1);
    tog_cnt = 0;
    repeat (5) @(negedge clk);
    check("abort_no_toggle", tog_cnt, 0);
    check("abort_no_more_falls", fall_cnt, 5);
    rst1_n = 1'b1;
    und_cnt = 0;
    wait_frame(w, falls, low, lat, gap);
    check("post_rst_latency", lat, 100);
    check("post_rst_word", w, 16'h0000);
    check("post_rst_underrun", und_cnt, 1);

    // 6: PD_MODE = 2'b11
    @(negedge clk);
    rst1_n = 1'b0;
    sel = 1'b1;
    rst2_n = 1'b1;
    push(12'hFFF, waited);
    wait_frame(w, falls, low, lat, gap);
    check("pd_word", w, 16'h3FFF);
    check("pd_falls", falls, 16);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
